release_scheduler: RTL and testbench

RELEASE_SCHEDULER -- requirements
Module: release_scheduler

---
 rtl/release_scheduler.sv | 112 +++++++++++
 tb/tb_release_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/release_scheduler.sv
// release_scheduler: round-robin release of completed bursts from response memory.
// Picks a ready UID, drains its beats downstream, then pulses a free to the allocator.
module release_scheduler #(
    parameter int NUM_UIDS = 16,
    parameter int MAX_LEN  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UIDS-1:0]         ready_vec,
    output logic [$clog2(NUM_UIDS)-1:0] uid_to_free,
    input  logic                        rm_valid,
    input  logic                        rm_last,
    output logic                        rm_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        free_req,
    output logic [$clog2(NUM_UIDS)-1:0] free_uid,
    output logic                        busy,
    output logic                        overrun_err
);

    localparam int UID_W = $clog2(NUM_UIDS);
    localparam int CNT_W = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, FREE} state_t;

    state_t           state;
    logic [UID_W-1:0] rr_ptr;
    logic [UID_W-1:0] cur_uid;
    logic [CNT_W-1:0] beat_cnt;

    logic             grant_found;
    logic [UID_W-1:0] grant_uid;
    logic [UID_W-1:0] scan_idx;
    logic             in_drain;
    logic             transfer;

    // Round-robin search: first set ready bit at or after rr_ptr, wrapping modulo NUM_UIDS.
    always_comb begin
        grant_found = 1'b0;
        grant_uid   = rr_ptr;
        scan_idx    = rr_ptr;
        for (int i = 0; i < NUM_UIDS; i++) begin
            scan_idx = rr_ptr + UID_W'(i);
            if (!grant_found && ready_vec[scan_idx]) begin
                grant_found = 1'b1;
                grant_uid   = scan_idx;
            end
        end
    end

    // Handshake pass-through while draining; rst forces the handshake off so no beat moves.
    always_comb begin
        in_drain  = (state == DRAIN) && !rst;
        out_valid = in_drain && rm_valid;
        rm_ready  = in_drain && out_ready;
        transfer  = in_drain && rm_valid && out_ready;
        busy      = (state != IDLE) && !rst;
    end

    assign uid_to_free = cur_uid;

    // Scheduler FSM with registered free pulse and sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_uid     <= '0;
            beat_cnt    <= '0;
            free_uid    <= '0;
            free_req    <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    free_req <= 1'b0;
                    if (grant_found) begin
                        cur_uid  <= grant_uid;
                        beat_cnt <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (transfer) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        if (rm_last) begin
                            state    <= FREE;
                            free_req <= 1'b1;
                            free_uid <= cur_uid;
                        end else if (beat_cnt == CNT_W'(MAX_LEN - 1)) begin
                            // Burst ran past MAX_LEN without a last beat: give the UID back anyway.
                            overrun_err <= 1'b1;
                            state       <= FREE;
                            free_req    <= 1'b1;
                            free_uid    <= cur_uid;
                        end
                    end
                end
                FREE: begin
                    free_req <= 1'b0;
                    rr_ptr   <= cur_uid + UID_W'(1);
                    state    <= IDLE;
                end
                default: begin
                    free_req <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_release_scheduler.sv
// Bench for release_scheduler: behavioural reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_release_scheduler;

    localparam int N       = 16;
    localparam int MAX_LEN = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  ready_vec;
    logic [3:0]    uid_to_free;
    logic          rm_valid;
    logic          rm_last;
    logic          rm_ready;
    logic          out_valid;
    logic          out_ready;
    logic          free_req;
    logic [3:0]    free_uid;
    logic          busy;
    logic          overrun_err;

    int compared   = 0;
    int mismatched = 0;

    release_scheduler #(.NUM_UIDS(N), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .ready_vec  (ready_vec),
        .uid_to_free(uid_to_free),
        .rm_valid   (rm_valid),
        .rm_last    (rm_last),
        .rm_ready   (rm_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .free_req   (free_req),
        .free_uid   (free_uid),
        .busy       (busy),
        .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    // Response memory: bursts of blen beats (blen==0 means rm_last never asserts).
    int blen = 1;
    int sent = 0;
    int total_xfers = 0;
    int free_cnt = 0;
    assign rm_last = (blen != 0) && (sent == blen - 1);

    always @(posedge clk) begin
        if (rst || free_req) sent <= 0;
        else if (out_valid && rm_ready) sent <= sent + 1;
        if (!rst && out_valid && rm_ready) total_xfers <= total_xfers + 1;
        if (free_req) free_cnt <= free_cnt + 1;
    end

    // Reference model: which UID is being served, how many beats it has moved,
    // whether its free is pending, and where the next search starts.
    int serving   = -1;
    int beats     = 0;
    bit freeing   = 0;
    int ptr       = 0;
    bit ovr       = 0;
    int shown_uid = 0;
    int last_free = 0;
    bit model_ok  = 0;

    always @(posedge clk) begin
        if (rst) begin
            serving = -1; beats = 0; freeing = 0; ptr = 0; ovr = 0;
            shown_uid = 0; last_free = 0; model_ok = 1;
        end else if (serving < 0) begin
            for (int k = 0; k < N; k++) begin
                if (serving < 0 && ready_vec[(ptr + k) % N]) begin
                    serving   = (ptr + k) % N;
                    shown_uid = serving;
                    beats     = 0;
                end
            end
        end else if (freeing) begin
            ptr     = (serving + 1) % N;
            serving = -1;
            freeing = 0;
        end else if (rm_valid && out_ready) begin
            beats++;
            if (rm_last) begin
                freeing = 1; last_free = serving;
            end else if (beats == MAX_LEN) begin
                ovr = 1; freeing = 1; last_free = serving;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_ok) begin
            bit draining;
            draining = (serving >= 0) && !freeing && !rst;
            check("busy", int'(busy), int'((serving >= 0) && !rst));
            check("out_valid", int'(out_valid), int'(draining && rm_valid));
            check("rm_ready", int'(rm_ready), int'(draining && out_ready));
            check("free_req", int'(free_req), int'(freeing));
            check("free_uid", int'(free_uid), last_free);
            check("uid_to_free", int'(uid_to_free), shown_uid);
            check("overrun_err", int'(overrun_err), int'(ovr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy();
        int n = 0;
        while (!busy && n < 50) begin step(); n++; end
        check("busy_timeout", int'(busy), 1);
    endtask

    task automatic wait_sent(input int target);
        int n = 0;
        while (sent != target && n < 50) begin step(); n++; end
        check("sent_timeout", sent, target);
    endtask

    // Waits for the free pulse, clears that ready bit as upstream would, and
    // steps into the following IDLE cycle.
    task automatic wait_free(output int uid, output int cyc);
        bit got = 0;
        uid = -1;
        cyc = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            step();
            cyc++;
            if (free_req) begin
                got = 1;
                uid = int'(free_uid);
                ready_vec[free_uid] = 1'b0;
            end
        end
        check("free_timeout", int'(got), 1);
        step();
        check("idle_after_free", int'(busy), 0);
    endtask

    initial begin
        int u, c, x0, f0;
        rst = 1'b1; ready_vec = '0; rm_valid = 1'b1; out_ready = 1'b1;
        repeat (3) step();
        check("rst_busy", int'(busy), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_rm_ready", int'(rm_ready), 0);
        check("rst_free_req", int'(free_req), 0);
        rst = 1'b0;
        step();
        check("reset_uid", int'(uid_to_free), 0);
        check("reset_ovr", int'(overrun_err), 0);

        // Single UID, 3-beat burst.
        blen = 3; x0 = total_xfers;
        ready_vec = 16'h0004;
        wait_busy();
        check("t1_uid", int'(uid_to_free), 2);
        wait_free(u, c);
        check("t1_free_uid", u, 2);
        check("t1_xfers", total_xfers - x0, 3);

        // rr_ptr is now 3: UID 3 wins over UID 1.
        blen = 2;
        ready_vec = 16'h000A;
        wait_free(u, c);
        check("t2_first", u, 3);
        wait_free(u, c);
        check("t2_second", u, 1);

        // Single-beat latency: free_req two cycles after the request is seen.
        blen = 1;
        ready_vec = 16'h0800;
        wait_free(u, c);
        check("t3_uid", u, 11);
        check("t3_latency", c, 2);

        // Round-robin wrap: serve 14 so the pointer sits at 15, then 15 then 0.
        ready_vec = 16'h4000;
        wait_free(u, c);
        check("t4_pre", u, 14);
        blen = 2;
        ready_vec = 16'h8001;
        wait_free(u, c);
        check("t4_wrap_first", u, 15);
        wait_free(u, c);
        check("t4_wrap_second", u, 0);

        // Backpressure mid-burst.
        blen = 4; x0 = total_xfers;
        ready_vec = 16'h0010;
        wait_sent(2);
        out_ready = 1'b0;
        repeat (5) begin
            step();
            check("t5_rm_ready_low", int'(rm_ready), 0);
        end
        check("t5_stalled", total_xfers - x0, 2);
        out_ready = 1'b1;
        wait_free(u, c);
        check("t5_uid", u, 4);
        check("t5_xfers", total_xfers - x0, 4);

        // ready_vec toggling during DRAIN does not disturb the grant.
        blen = 4; f0 = free_cnt;
        ready_vec = 16'h0040;
        wait_busy();
        ready_vec = 16'hFFFF; step();
        check("t6_hold_a", int'(uid_to_free), 6);
        ready_vec = 16'h0000; step();
        check("t6_hold_b", int'(uid_to_free), 6);
        ready_vec = 16'h0002; step();
        check("t6_hold_c", int'(uid_to_free), 6);
        wait_free(u, c);
        check("t6_first", u, 6);
        check("t6_one_free", free_cnt - f0, 1);
        wait_free(u, c);
        check("t6_second", u, 1);

        // Overrun: no last beat within MAX_LEN beats.
        blen = 0; x0 = total_xfers;
        ready_vec = 16'h0020;
        wait_free(u, c);
        check("t7_uid", u, 5);
        check("t7_xfers", total_xfers - x0, 8);
        check("t7_ovr", int'(overrun_err), 1);
        blen = 2;
        ready_vec = 16'h0200;
        wait_free(u, c);
        check("t7_next_uid", u, 9);
        check("t7_ovr_sticky", int'(overrun_err), 1);

        // Reset mid-DRAIN after two beats: no free, search restarts at UID 0.
        blen = 5; f0 = free_cnt;
        ready_vec = 16'h0100;
        wait_sent(2);
        rst = 1'b1;
        ready_vec = 16'h0101;
        step();
        rst = 1'b0;
        check("t8_no_free", free_cnt - f0, 0);
        check("t8_ovr_clear", int'(overrun_err), 0);
        check("t8_uid_reset", int'(uid_to_free), 0);
        wait_free(u, c);
        check("t8_first", u, 0);
        wait_free(u, c);
        check("t8_second", u, 8);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
